// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Debounces NUM_BTN active-low push buttons (one FSM per button). Every
//   press-and-release is queued as a per-button pending bit. A round-robin
//   arbiter then hands the events, one at a time, to a registered
//   valid/ready event slot.
//   Optional: define BUTTON_EVENT_ARBITER_DROP_CNT_EN to add an 8-bit
//   saturating drop_count output. It counts release events that were
//   discarded because that button already had an event pending.
module button_event_arbiter #(
  parameter int NUM_BTN        = 4,
  parameter int DEBOUNCE_TICKS = 500000,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         btn_n,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic [CNT_W-1:0]           evt_count,
  output logic [NUM_BTN-1:0]         pending
`ifdef BUTTON_EVENT_ARBITER_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int ID_W = $clog2(NUM_BTN);
  localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [ID_W:0]   NUM_BTN_W = (ID_W + 1)'(NUM_BTN);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_BTN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSING = 2'd1,
    HELD     = 2'd2
  } db_state_t;

  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;
  logic [NUM_BTN-1:0] release_evt;

  logic [NUM_BTN-1:0] pending_reg;
  logic [NUM_BTN-1:0] pending_next;
  logic [NUM_BTN-1:0] grant_clr;
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    ptr_next;
  logic               evt_valid_reg;
  logic [ID_W-1:0]    evt_id_reg;
  logic [CNT_W-1:0]   evt_count_reg;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W:0]      cand;
  logic               load;

  // Two-flop synchronizer. It resets to 1 (released) so that no spurious press is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
      db_state_t       state_reg;
      db_state_t       state_next;
      logic [DB_W-1:0] cnt_reg;
      logic [DB_W-1:0] cnt_next;
      logic            rel;

      // Debounce state and tick counter registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Next state: qualify a stable low level, and flag the release of a held button
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rel        = 1'b0;
        case (state_reg)
          IDLE: begin
            if (!sync2_reg[gi]) begin
              state_next = PRESSING;
              cnt_next   = '0;
            end
          end
          PRESSING: begin
            if (sync2_reg[gi]) begin
              state_next = IDLE;        // bounce or glitch: drop it silently
              cnt_next   = '0;
            end else if (cnt_reg == DB_LAST) begin
              state_next = HELD;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          HELD: begin
            if (sync2_reg[gi]) begin
              state_next = IDLE;
              rel        = 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign release_evt[gi] = rel;
    end
  endgenerate

  // Round-robin search: take the first pending bit at or above ptr, wrapping around.
  // The loop runs from the highest offset down, so the nearest hit is written last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (ID_W + 1)'(k);
      if (cand >= NUM_BTN_W) begin
        cand = cand - NUM_BTN_W;
      end
      if (pending_reg[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign load     = !evt_valid_reg || evt_ready;
  assign ptr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;

  // Pending update: the granted bit is cleared. A new release in the same cycle sets it again.
  always_comb begin
    grant_clr = '0;
    if (load && grant_found) begin
      grant_clr[grant_idx] = 1'b1;
    end
    pending_next = (pending_reg & ~grant_clr) | release_evt;
  end

  // Event slot, arbiter pointer, pending flags and handshake counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      ptr_reg       <= '0;
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      evt_count_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      if (evt_valid_reg && evt_ready) begin
        evt_count_reg <= evt_count_reg + 1'b1;
      end
      if (load) begin
        evt_valid_reg <= grant_found;
        if (grant_found) begin
          evt_id_reg <= grant_idx;
          ptr_reg    <= ptr_next;
        end
      end
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;
  assign evt_count = evt_count_reg;
  assign pending   = pending_reg;

`ifdef BUTTON_EVENT_ARBITER_DROP_CNT_EN
  logic       drop_evt;
  logic [7:0] drop_count_reg;

  // An event is lost when its pending bit is already set and is not being drained this cycle.
  assign drop_evt = |(release_evt & pending_reg & ~grant_clr);

  // Saturating count of lost events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else if (drop_evt && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  assign drop_count = drop_count_reg;
`endif

endmodule
